apb_rb_bridge_v2: RTL and testbench

- Parametrised APB4-to-generic-register-bus bridge; successor to the existing combinational APB/register-bus bridge in the UART subsystem.
- Registers each APB transfer and issues a single-cycle read or write strobe with byte enables.
- Waits a bounded number of cycles for the ack, then returns a registered PREADY/PRDATA/PSLVERR.
- Adds address-range, alignment and timeout error detection, plus a saturating error counter.

---
 rtl/apb_rb_bridge_v2_if.sv | 45 ++++
 rtl/apb_rb_bridge_v2.sv | 139 +++++++++++++
 tb/tb_apb_rb_bridge_v2.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_rb_bridge_v2_if.sv
// Bus bundle between the APB4 side and the generic register bus.
// The bridge takes the slave view; the driver/responder takes the master view.
interface apb_rb_bridge_v2_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   apb_paddr;
    logic                    apb_psel;
    logic                    apb_penable;
    logic                    apb_pwrite;
    logic [DATA_WIDTH-1:0]   apb_pwdata;
    logic [DATA_WIDTH/8-1:0] apb_pstrb;
    logic                    apb_pready;
    logic [DATA_WIDTH-1:0]   apb_prdata;
    logic                    apb_pslverr;

    logic                    apb_rstrobe;
    logic [ADDR_WIDTH-1:0]   apb_raddr;
    logic [DATA_WIDTH-1:0]   apb_rdata;
    logic                    apb_rack;
    logic                    apb_raddrerr;
    logic                    apb_wstrobe;
    logic [ADDR_WIDTH-1:0]   apb_waddr;
    logic [DATA_WIDTH-1:0]   apb_wdata;
    logic [DATA_WIDTH/8-1:0] apb_wbe;
    logic                    apb_wack;
    logic                    apb_waddrerr;
    logic [7:0]              apb_err_cnt;

    modport slave (
        input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
        input  apb_rdata, apb_rack, apb_raddrerr, apb_wack, apb_waddrerr,
        output apb_pready, apb_prdata, apb_pslverr,
        output apb_rstrobe, apb_raddr, apb_wstrobe, apb_waddr, apb_wdata, apb_wbe,
        output apb_err_cnt
    );

    modport master (
        output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
        output apb_rdata, apb_rack, apb_raddrerr, apb_wack, apb_waddrerr,
        input  apb_pready, apb_prdata, apb_pslverr,
        input  apb_rstrobe, apb_raddr, apb_wstrobe, apb_waddr, apb_wdata, apb_wbe,
        input  apb_err_cnt
    );
endinterface

// File: rtl/apb_rb_bridge_v2.sv
// APB4 to register-bus bridge: one strobe per transfer, bounded ack wait,
// range/alignment/timeout error detection and a saturating error counter.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for an APB setup phase
// S_STROBE | single-cycle read/write strobe issued from the latches
// S_WAIT   | strobe low, waiting for ack/addrerr or timeout
// S_DONE   | pready high for one cycle with pslverr/prdata
module apb_rb_bridge_v2 #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_RANGE = 4096,
    parameter int TIMEOUT    = 16
) (
    input logic             apb_pclk,
    input logic             apb_preset,
    apb_rb_bridge_v2_if.slave bus
);
    localparam int BW  = DATA_WIDTH / 8;
    localparam int LSB = $clog2(BW);
    localparam int TW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]       TMR_LOAD  = TW'(TIMEOUT);
    localparam logic [ADDR_WIDTH:0] RANGE_LIM = (ADDR_WIDTH + 1)'(ADDR_RANGE);

    typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BW-1:0]         be_q;
    logic                  pwrite_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [TW-1:0]         tmr_q;
    logic [7:0]            err_cnt_q;

    logic setup, bad_addr, req_ack, req_err, resp, tmr_done, busy;

    assign setup    = bus.apb_psel && !bus.apb_penable;
    assign bad_addr = (bus.apb_paddr[LSB-1:0] != '0) ||
                      ({1'b0, bus.apb_paddr} >= RANGE_LIM);
    assign req_ack  = pwrite_q ? bus.apb_wack     : bus.apb_rack;
    assign req_err  = pwrite_q ? bus.apb_waddrerr : bus.apb_raddrerr;
    assign resp     = req_ack || req_err;
    // Timer counts the STROBE cycle; reaching 1 means this is the last allowed cycle.
    assign tmr_done = (TIMEOUT > 0) && (tmr_q == TW'(1));
    assign busy     = (state_q == S_STROBE) || (state_q == S_WAIT);

    always_ff @(posedge apb_pclk or posedge apb_preset) begin
        if (apb_preset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    if (bad_addr) begin
                        state_d = S_DONE;
                    end else if (bus.apb_pwrite && (bus.apb_pstrb == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_STROBE;
                    end
                end
            end
            S_STROBE, S_WAIT: begin
                if (!bus.apb_psel) begin
                    state_d = S_IDLE;
                end else if (resp || tmr_done) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge apb_pclk or posedge apb_preset) begin
        if (apb_preset) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            pwrite_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            tmr_q    <= '0;
        end else if ((state_q == S_IDLE) && setup) begin
            addr_q   <= bus.apb_paddr;
            wdata_q  <= bus.apb_pwdata;
            be_q     <= bus.apb_pstrb;
            pwrite_q <= bus.apb_pwrite;
            err_q    <= bad_addr;
            rdata_q  <= '0;
            tmr_q    <= TMR_LOAD;
        end else if (busy && bus.apb_psel) begin
            // Error wins over ack, and errored reads never expose data.
            if (resp) begin
                err_q   <= req_err;
                rdata_q <= (!pwrite_q && !req_err) ? bus.apb_rdata : '0;
            end else if (tmr_done) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end else begin
                tmr_q <= tmr_q - TW'(1);
            end
        end
    end

    always_ff @(posedge apb_pclk or posedge apb_preset) begin
        if (apb_preset) begin
            err_cnt_q <= '0;
        end else if ((state_q == S_DONE) && err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.apb_pready  = (state_q == S_DONE);
    assign bus.apb_pslverr = (state_q == S_DONE) && err_q;
    assign bus.apb_prdata  = (state_q == S_DONE) ? rdata_q : '0;
    assign bus.apb_rstrobe = (state_q == S_STROBE) && !pwrite_q;
    assign bus.apb_wstrobe = (state_q == S_STROBE) && pwrite_q;
    assign bus.apb_raddr   = addr_q;
    assign bus.apb_waddr   = addr_q;
    assign bus.apb_wdata   = wdata_q;
    assign bus.apb_wbe     = be_q;
    assign bus.apb_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_apb_rb_bridge_v2.sv
// Directed bench for apb_rb_bridge_v2 with hand-computed expectations.
module tb_apb_rb_bridge_v2;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int AR = 256;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    apb_rb_bridge_v2_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_rb_bridge_v2 #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_RANGE(AR), .TIMEOUT(TO)
    ) dut (
        .apb_pclk  (clk),
        .apb_preset(rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.apb_psel = 1'b0; bus.apb_penable = 1'b0; bus.apb_pwrite = 1'b0;
        bus.apb_paddr = '0; bus.apb_pwdata = '0; bus.apb_pstrb = '0;
        bus.apb_rdata = '0; bus.apb_rack = 1'b0; bus.apb_raddrerr = 1'b0;
        bus.apb_wack = 1'b0; bus.apb_waddrerr = 1'b0;
    endtask

    // Cycle 0 is the setup phase; ack/err are driven ack_at cycles after the strobe.
    task automatic xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [3:0] st, input int ack_at, input bit do_ack,
                        input bit do_err, input logic [DW-1:0] rd,
                        output int rdy_cyc, output int strb_cnt, output logic [DW-1:0] prd,
                        output bit slverr, output bit early_nz,
                        output logic [AW-1:0] s_addr, output logic [DW-1:0] s_wd,
                        output logic [3:0] s_be);
        int strb_at;
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0; bus.apb_pwrite = wr;
        bus.apb_paddr = addr; bus.apb_pwdata = wd; bus.apb_pstrb = st;
        bus.apb_rdata = rd;
        rdy_cyc = -1; strb_cnt = 0; strb_at = -1; prd = '0; slverr = 1'b0;
        early_nz = 1'b0; s_addr = '0; s_wd = '0; s_be = '0;
        tick();
        bus.apb_penable = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            bus.apb_rack = 1'b0; bus.apb_wack = 1'b0;
            bus.apb_raddrerr = 1'b0; bus.apb_waddrerr = 1'b0;
            if (bus.apb_rstrobe || bus.apb_wstrobe) begin
                strb_cnt++;
                strb_at = c;
                s_addr = wr ? bus.apb_waddr : bus.apb_raddr;
                s_wd = bus.apb_wdata;
                s_be = bus.apb_wbe;
            end
            if (bus.apb_pready) begin
                rdy_cyc = c;
                prd = bus.apb_prdata;
                slverr = bus.apb_pslverr;
                break;
            end
            if (bus.apb_prdata != '0) early_nz = 1'b1;
            if (strb_at > 0 && (c - strb_at) == ack_at) begin
                if (wr) begin
                    bus.apb_wack = do_ack; bus.apb_waddrerr = do_err;
                end else begin
                    bus.apb_rack = do_ack; bus.apb_raddrerr = do_err;
                end
            end
            tick();
        end
        idle_bus();
        tick();
        if (bus.apb_prdata != '0) early_nz = 1'b1;
    endtask

    int              rc, sc;
    logic [DW-1:0]   prd, swd;
    logic [AW-1:0]   sad;
    logic [3:0]      sbe;
    bit              se, enz;

    initial begin
        idle_bus();
        tick();
        tick();
        check("rst_pready", bus.apb_pready, 0);
        check("rst_pslverr", bus.apb_pslverr, 0);
        check("rst_prdata", bus.apb_prdata, 0);
        check("rst_strobes", {bus.apb_rstrobe, bus.apb_wstrobe}, 0);
        check("rst_err_cnt", bus.apb_err_cnt, 0);
        rst = 1'b0;
        tick();

        // Write, ack in the strobe cycle
        xfer(1, 12'h010, 32'hDEADBEEF, 4'b0011, 0, 1, 0, '0, rc, sc, prd, se, enz, sad, swd, sbe);
        check("wr_strobes", sc, 1);
        check("wr_ready_cyc", rc, 2);
        check("wr_slverr", se, 0);
        check("wr_waddr", sad, 12'h010);
        check("wr_wdata", swd, 32'hDEADBEEF);
        check("wr_wbe", sbe, 4'b0011);

        // Read, ack on the last cycle before timeout
        xfer(0, 12'h020, '0, 4'b0000, 3, 1, 0, 32'h12345678, rc, sc, prd, se, enz, sad, swd, sbe);
        check("rd_strobes", sc, 1);
        check("rd_ready_cyc", rc, 5);
        check("rd_prdata", prd, 32'h12345678);
        check("rd_slverr", se, 0);
        check("rd_prdata_idle", enz, 0);
        check("rd_raddr", sad, 12'h020);

        // Read timeout
        xfer(0, 12'h030, '0, 4'b0000, 0, 0, 0, 32'hA5A5A5A5, rc, sc, prd, se, enz, sad, swd, sbe);
        exp_cnt = 1;
        check("to_ready_cyc", rc, 5);
        check("to_slverr", se, 1);
        check("to_prdata", prd, 0);
        check("to_err_cnt", bus.apb_err_cnt, exp_cnt);

        // Misaligned read
        xfer(0, 12'h002, '0, 4'b0000, 0, 1, 0, 32'h1, rc, sc, prd, se, enz, sad, swd, sbe);
        exp_cnt = 2;
        check("mis_strobes", sc, 0);
        check("mis_ready_cyc", rc, 1);
        check("mis_slverr", se, 1);
        check("mis_err_cnt", bus.apb_err_cnt, exp_cnt);

        // Out-of-range write
        xfer(1, 12'h100, 32'h1, 4'b1111, 0, 1, 0, '0, rc, sc, prd, se, enz, sad, swd, sbe);
        exp_cnt = 3;
        check("rng_strobes", sc, 0);
        check("rng_ready_cyc", rc, 1);
        check("rng_slverr", se, 1);
        check("rng_err_cnt", bus.apb_err_cnt, exp_cnt);

        // Last in-range word is fine
        xfer(1, 12'h0FC, 32'h55, 4'b1000, 1, 1, 0, '0, rc, sc, prd, se, enz, sad, swd, sbe);
        check("edge_strobes", sc, 1);
        check("edge_ready_cyc", rc, 3);
        check("edge_slverr", se, 0);

        // Write with no byte strobes
        xfer(1, 12'h040, 32'h77, 4'b0000, 0, 1, 0, '0, rc, sc, prd, se, enz, sad, swd, sbe);
        check("nostrb_strobes", sc, 0);
        check("nostrb_ready_cyc", rc, 1);
        check("nostrb_slverr", se, 0);
        check("nostrb_err_cnt", bus.apb_err_cnt, exp_cnt);

        // Write ack and addrerr together
        xfer(1, 12'h044, 32'h88, 4'b0001, 0, 1, 1, '0, rc, sc, prd, se, enz, sad, swd, sbe);
        exp_cnt = 4;
        check("both_wr_ready_cyc", rc, 2);
        check("both_wr_slverr", se, 1);
        check("both_wr_err_cnt", bus.apb_err_cnt, exp_cnt);

        // Read ack and addrerr together: data forced to 0
        xfer(0, 12'h048, '0, 4'b0000, 1, 1, 1, 32'hCAFEF00D, rc, sc, prd, se, enz, sad, swd, sbe);
        exp_cnt = 5;
        check("both_rd_ready_cyc", rc, 3);
        check("both_rd_slverr", se, 1);
        check("both_rd_prdata", prd, 0);
        check("both_rd_err_cnt", bus.apb_err_cnt, exp_cnt);

        // Protocol abort: psel dropped in STROBE
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0; bus.apb_paddr = 12'h050; bus.apb_pwrite = 1'b0;
        tick();
        check("abort_strobe", bus.apb_rstrobe, 1);
        bus.apb_psel = 1'b0;
        rc = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.apb_pready || bus.apb_rstrobe) rc++;
        end
        check("abort_no_ready", rc, 0);
        check("abort_err_cnt", bus.apb_err_cnt, exp_cnt);

        // Reset asserted during WAIT
        bus.apb_psel = 1'b1; bus.apb_penable = 1'b0; bus.apb_paddr = 12'h060; bus.apb_pwrite = 1'b0;
        tick();
        bus.apb_penable = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_wait_ready", bus.apb_pready, 0);
        check("rst_wait_raddr", bus.apb_raddr, 0);
        check("rst_wait_err_cnt", bus.apb_err_cnt, 0);
        exp_cnt = 0;
        idle_bus();
        tick();
        rst = 1'b0;
        tick();
        xfer(1, 12'h070, 32'h0BADF00D, 4'b1111, 0, 1, 0, '0, rc, sc, prd, se, enz, sad, swd, sbe);
        check("post_rst_ready_cyc", rc, 2);
        check("post_rst_slverr", se, 0);
        check("post_rst_wdata", swd, 32'h0BADF00D);

        // Saturation of the error counter
        for (int i = 0; i < 260; i++) begin
            xfer(0, 12'h001, '0, 4'b0000, 0, 1, 0, '0, rc, sc, prd, se, enz, sad, swd, sbe);
            if (exp_cnt < 255) exp_cnt++;
            if (i == 254) check("sat_255", bus.apb_err_cnt, exp_cnt);
        end
        check("sat_hold", bus.apb_err_cnt, 255);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
